// File: rtl/seq_pkg.sv
// Shared limits, default pattern and state-width helper for the sequence detector.
package seq_pkg;
   localparam int SEQ_W_MIN = 2;
   localparam int SEQ_W_MAX = 16;
   localparam logic [SEQ_W_MAX-1:0] DEFAULT_PATTERN = 16'b10010;

   function automatic int state_w(input int seq_w);
      return $clog2(seq_w + 1);
   endfunction
endpackage

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Updates on the edge after inc; no backpressure (holds at all-ones).
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign cnt = r_cnt;
endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector: out pulses one clock after the completing bit; in_valid=0 stalls history.
// Optional saturating match counter built only when SEQ_DETECT_CNT_EN is defined.
module seq_detect_param
   import seq_pkg::*;
#(
   parameter int                 SEQ_W   = 5,
   parameter logic [SEQ_W-1:0]   PATTERN = DEFAULT_PATTERN[SEQ_W-1:0],
   parameter bit                 OVERLAP = 1'b1,
   parameter int                 CNT_W   = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic                       in,
   input  logic                       clear,
   input  logic                       pat_load,
   input  logic [SEQ_W-1:0]           pat_in,
   output logic                       out,
   output logic [state_w(SEQ_W)-1:0]  state,
   output logic [CNT_W-1:0]           match_cnt
);
   localparam int FW = state_w(SEQ_W);
   localparam logic [FW-1:0] FILL_MAX = FW'(SEQ_W);
   localparam logic [FW-1:0] FILL_THR = FW'(SEQ_W - 1);

   if (SEQ_W < SEQ_W_MIN || SEQ_W > SEQ_W_MAX) begin : g_bad_seq_w
      $error("seq_detect_param: SEQ_W out of range");
   end

   logic [SEQ_W-1:0] r_hist;
   logic [FW-1:0]    r_fill;
   logic [SEQ_W-1:0] r_pat;
   logic             r_out;
   logic [SEQ_W-1:0] w_nxt;
   logic             w_match;

   assign w_nxt   = {r_hist[SEQ_W-2:0], in};
   // fill only needs SEQ_W-1 because the incoming bit completes the window
   assign w_match = (w_nxt == r_pat) && (r_fill >= FILL_THR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hist <= '0;
         r_fill <= '0;
         r_pat  <= PATTERN;
         r_out  <= 1'b0;
      end else begin
         r_out <= 1'b0;
         if (clear || pat_load) begin
            r_hist <= '0;
            r_fill <= '0;
            if (pat_load) r_pat <= pat_in;
         end else if (in_valid) begin
            r_hist <= w_nxt;
            r_out  <= w_match;
            if (w_match && !OVERLAP)    r_fill <= '0;
            else if (r_fill != FILL_MAX) r_fill <= r_fill + 1'b1;
         end
      end
   end

   assign out   = r_out;
   assign state = r_fill;

`ifdef SEQ_DETECT_CNT_EN
   logic w_inc;
   assign w_inc = in_valid && !clear && !pat_load && w_match;

   sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (reset),
      .inc (w_inc),
      .clr (clear),
      .cnt (match_cnt)
   );
`else
   assign match_cnt = '0;
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench: overlap/non-overlap/saturating variants share one stimulus bus.
module tb_seq_detect_param;
`ifdef SEQ_DETECT_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       din = 1'b0;
   logic       clear = 1'b0;
   logic       pat_load = 1'b0;
   logic [4:0] pat_in = 5'b0;

   logic       out_ov, out_no, out_sat;
   logic [2:0] st_ov, st_no, st_sat;
   logic [7:0] cnt_ov, cnt_no;
   logic [1:0] cnt_sat;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   seq_detect_param u_ov (
      .clk(clk), .reset(rst), .in_valid(in_valid), .in(din), .clear(clear),
      .pat_load(pat_load), .pat_in(pat_in), .out(out_ov), .state(st_ov), .match_cnt(cnt_ov));

   seq_detect_param #(.OVERLAP(1'b0)) u_no (
      .clk(clk), .reset(rst), .in_valid(in_valid), .in(din), .clear(clear),
      .pat_load(pat_load), .pat_in(pat_in), .out(out_no), .state(st_no), .match_cnt(cnt_no));

   seq_detect_param #(.CNT_W(2)) u_sat (
      .clk(clk), .reset(rst), .in_valid(in_valid), .in(din), .clear(clear),
      .pat_load(pat_load), .pat_in(pat_in), .out(out_sat), .state(st_sat), .match_cnt(cnt_sat));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one bit for one edge, then sample just after that edge.
   task automatic send(input logic b);
      in_valid = 1'b1;
      din      = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   task automatic do_load(input logic [4:0] p);
      pat_load = 1'b1;
      pat_in   = p;
      @(posedge clk);
      #1;
      pat_load = 1'b0;
   endtask

   logic [7:0] stream   = 8'b10010010;
   logic [7:0] exp_ov_o = 8'b00001001;
   logic [7:0] exp_no_o = 8'b00001000;
   logic [4:0] rl_bits  = 5'b11100;
   logic [4:0] old_bits = 5'b10010;

   initial begin
      // reset asserted from time 0, checked before any clock edge
      #3;
      check("rst_state", st_ov, 0);
      check("rst_out", out_ov, 0);
      check("rst_cnt", cnt_ov, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // overlap vs non-overlap on 1,0,0,1,0,0,1,0
      for (int i = 0; i < 8; i++) begin
         send(stream[7-i]);
         check($sformatf("ov_out_b%0d", i + 1), out_ov, exp_ov_o[7-i]);
         check($sformatf("no_out_b%0d", i + 1), out_no, exp_no_o[7-i]);
      end
      check("ov_state", st_ov, 5);
      check("no_state", st_no, 3);
      check("ov_cnt", cnt_ov, CNT_EN ? 2 : 0);
      check("no_cnt", cnt_no, CNT_EN ? 1 : 0);

      do_clear();
      check("clr_state", st_ov, 0);
      check("clr_cnt", cnt_ov, 0);
      check("clr_out", out_ov, 0);

      // gap of three idle cycles between bits 3 and 4
      send(1'b1); send(1'b0); send(1'b0);
      for (int i = 0; i < 3; i++) begin
         idle();
         check($sformatf("gap_state%0d", i), st_ov, 3);
         check($sformatf("gap_out%0d", i), out_ov, 0);
      end
      send(1'b1);
      check("gap_out_b4", out_ov, 0);
      send(1'b0);
      check("gap_out_b5", out_ov, 1);
      idle();
      check("gap_out_after", out_ov, 0);

      // reload pattern mid-stream
      do_clear();
      send(1'b1); send(1'b0); send(1'b0);
      do_load(5'b11100);
      check("load_state", st_ov, 0);
      for (int i = 0; i < 5; i++) begin
         send(rl_bits[4-i]);
         check($sformatf("rl_out_b%0d", i + 1), out_ov, (i == 4) ? 1 : 0);
      end
      for (int i = 0; i < 5; i++) begin
         send(old_bits[4-i]);
         check($sformatf("rl_old_b%0d", i + 1), out_ov, 0);
      end
      do_load(5'b10010);

      // asynchronous reset after bit 4
      send(1'b1); send(1'b0); send(1'b0); send(1'b1);
      check("pre_rst_state", st_ov, 4);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_state", st_ov, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(1'b0);
      check("post_rst_out", out_ov, 0);
      check("post_rst_state", st_ov, 1);

      // six overlapping matches saturate the 2-bit counter
      do_clear();
      send(1'b1); send(1'b0); send(1'b0); send(1'b1); send(1'b0);
      for (int k = 0; k < 5; k++) begin
         send(1'b0); send(1'b1); send(1'b0);
      end
      check("sat_cnt", cnt_sat, CNT_EN ? 3 : 0);
      check("wide_cnt", cnt_ov, CNT_EN ? 6 : 0);
      do_clear();
      check("sat_clr", cnt_sat, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter SEQ_W, default 5: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 5'b10010: reset value of the pattern register; MSB is the first bit expected.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches, 0 = non-overlapping.
REQ-004 Parameter CNT_W, default 8: match counter width.
REQ-005 Port clk, input, 1: single clock, rising-edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port in_valid, input, 1: in is sampled when high.
REQ-008 Port in, input, 1: serial data bit.
REQ-009 Port clear, input, 1: synchronous flush of history and counter.
REQ-010 Port pat_load, input, 1: load pat_in into the pattern register.
REQ-011 Port pat_in, input, SEQ_W: new pattern.
REQ-012 Port out, output, 1: one-cycle match pulse.
REQ-013 Port state, output, $clog2(SEQ_W+1): count of valid history bits.
REQ-014 Port match_cnt, output, CNT_W: saturating match count.

Function
REQ-015 Internal registers SHALL be hist[SEQ_W-1:0], fill (0..SEQ_W, saturating) and pat_r[SEQ_W-1:0].
REQ-016 Accepting a bit means the block updates hist <= {hist[SEQ_W-2:0], in} and increments fill, saturating at SEQ_W.
REQ-017 On a clock edge with in_valid=1, the block SHALL accept the bit.
REQ-018 The candidate nxt = {hist[SEQ_W-2:0], in}.
REQ-019 The match condition is: candidate nxt equals pat_r, and fill is at least SEQ_W-1.
REQ-020 When the match condition holds, out SHALL be 1 for exactly the cycle following that edge; otherwise out is 0.
REQ-021 Latency: one clock from the sampling edge of the completing bit to out.
REQ-022 With in_valid=0, hist and fill SHALL hold, and out SHALL be 0 on the next cycle.
REQ-023 If OVERLAP=1, history SHALL be kept after a match, so the trailing bits may start the next match.
REQ-024 If OVERLAP=0, on a match fill SHALL be set to 0 on the same edge, so no bit is reused.
REQ-025 clear=1 SHALL zero hist, fill, out and match_cnt on the next edge; pat_r is kept.
REQ-026 pat_load=1 SHALL set pat_r <= pat_in, and zero hist, fill and out, on the next edge.
REQ-027 Priority SHALL be clear/pat_load over in_valid; a bit presented in the same cycle is discarded.
REQ-028 If clear=1 and pat_load=1 in the same cycle, both actions SHALL take effect.
REQ-029 state SHALL equal fill.

Reset
REQ-030 While reset=1, the block SHALL hold hist=0, fill=0, out=0, match_cnt=0 and pat_r=PATTERN, without waiting for a clock edge.
REQ-031 Reset asserted mid-stream SHALL discard partial history; after release, SEQ_W new bits are needed before any match.

Configuration
REQ-032 Macro SEQ_DETECT_CNT_EN defined: match_cnt SHALL increment by 1 on every cycle in which out rises to 1, and saturate at 2^CNT_W-1.
REQ-033 Macro SEQ_DETECT_CNT_EN undefined: the match_cnt port SHALL remain, be tied to 0, and no counter logic is built.

Structure
REQ-034 Package seq_pkg SHALL hold the SEQ_W range limits, the default PATTERN and the state-width function.
REQ-035 The saturating counter SHALL be one sub-module, sat_counter (CNT_W, inc, clr), instantiated only under SEQ_DETECT_CNT_EN.
REQ-036 The top SHALL hold the history, fill and compare logic.

Verification
REQ-037 Overlap: defaults, stream 1,0,0,1,0,0,1,0 with in_valid=1 -> out pulses after bit 5 and bit 8; match_cnt=2.
REQ-038 Non-overlap: OVERLAP=0, same stream -> out pulses after bit 5 only; match_cnt=1.
REQ-039 Gaps: same stream with in_valid=0 for 3 cycles between bits 3 and 4 -> one pulse after bit 5, state holds 3 during the gap.
REQ-040 Reload: pat_load with pat_in=5'b11100 after bit 3 (stream 1,0,0, load, then 1,1,1,0,0) -> out after the 5th post-load bit; no pulse for 10010.
REQ-041 Reset: reset pulse after bit 4 of 10010 -> state=0 immediately; bit 0 afterwards does not match.
REQ-042 Saturation: CNT_W=2, six overlapping matches -> match_cnt stops at 3; clear -> 0 next cycle.
